// File: rtl/signed_fixed_point_div.sv
// Iterative signed fixed-point divider, Q(D.F) / Q(D.F) -> Q(D.F).
// Radix-2 restoring loop on operand magnitudes, one quotient bit per cycle,
// sign applied and saturation resolved in a final cycle.
// Optional feature macro: FIXED_DIV_ROUND_EN (round half away from zero via
// one extra guard-bit iteration); when undefined the quotient truncates toward zero.
module signed_fixed_point_div #(
  parameter int unsigned D = 16,
  parameter int unsigned F = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [D+F-1:0]   a,
  input  logic [D+F-1:0]   b,
  output logic             ready,
  output logic             done,
  output logic [D+F-1:0]   q,
  output logic             ovf,
  output logic             div0
);

  localparam int unsigned W  = D + F;
`ifdef FIXED_DIV_ROUND_EN
  localparam int unsigned RND = 1;
`else
  localparam int unsigned RND = 0;
`endif
  // Quotient/dividend register width equals the iteration count.
  localparam int unsigned NB = W + F + RND;
  // Magnitude width with one spare bit so the rounding increment cannot wrap.
  localparam int unsigned MW = W + F + 1;
  localparam int unsigned CW = $clog2(NB + 1);

  localparam logic [W-1:0]  QMAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  QMIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [MW-1:0] NEG_LIM = MW'(1) << (W - 1);
  localparam logic [MW-1:0] POS_LIM = NEG_LIM - MW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NB-1:0]   dvd, dvd_n;
  logic [NB-1:0]   quo, quo_n;
  logic [W-1:0]    rem, rem_n;
  logic [W-1:0]    bmag, bmag_n;
  logic            sign_q, sign_q_n;
  logic            sign_a, sign_a_n;
  logic            ready_n, done_n, ovf_n, div0_n;
  logic [W-1:0]    q_n;

  logic [W-1:0]    amag;
  logic [W:0]      rem_sh;
  logic [MW-1:0]   mag;
  logic [MW-1:0]   mneg;

  // Operand magnitudes; |MIN| = 2^(W-1) is representable as unsigned W bits.
  always_comb begin
    amag = a[W-1] ? W'(-a) : a;
  end

  // Resolved quotient magnitude, with guard-bit rounding when enabled.
  always_comb begin
`ifdef FIXED_DIV_ROUND_EN
    mag = MW'(quo[NB-1:1]) + MW'(quo[0]);
`else
    mag = MW'(quo);
`endif
    mneg = MW'(0) - mag;
  end

  // Next-state and datapath/output next values.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dvd_n    = dvd;
    quo_n    = quo;
    rem_n    = rem;
    bmag_n   = bmag;
    sign_q_n = sign_q;
    sign_a_n = sign_a;
    q_n      = q;
    ovf_n    = ovf;
    div0_n   = div0;
    done_n   = 1'b0;
    rem_sh   = {rem, dvd[NB-1]};

    case (state)
      IDLE: begin
        if (start) begin
          sign_q_n = a[W-1] ^ b[W-1];
          sign_a_n = a[W-1];
          bmag_n   = b[W-1] ? W'(-b) : b;
          dvd_n    = NB'(amag) << (F + RND);
          quo_n    = '0;
          rem_n    = '0;
          cnt_n    = CW'(NB);
          state_n  = CALC;
        end
      end

      CALC: begin
        if (rem_sh >= {1'b0, bmag}) begin
          rem_n = W'(rem_sh - {1'b0, bmag});
          quo_n = {quo[NB-2:0], 1'b1};
        end else begin
          rem_n = rem_sh[W-1:0];
          quo_n = {quo[NB-2:0], 1'b0};
        end
        dvd_n = dvd << 1;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = FIN;
        end
      end

      FIN: begin
        if (bmag == '0) begin
          div0_n = 1'b1;
          ovf_n  = 1'b1;
          q_n    = sign_a ? QMIN : QMAX;
        end else if (!sign_q && (mag > POS_LIM)) begin
          div0_n = 1'b0;
          ovf_n  = 1'b1;
          q_n    = QMAX;
        end else if (sign_q && (mag > NEG_LIM)) begin
          div0_n = 1'b0;
          ovf_n  = 1'b1;
          q_n    = QMIN;
        end else begin
          div0_n = 1'b0;
          ovf_n  = 1'b0;
          q_n    = sign_q ? mneg[W-1:0] : mag[W-1:0];
        end
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    ready_n = (state_n == IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      quo    <= '0;
      rem    <= '0;
      bmag   <= '0;
      sign_q <= 1'b0;
      sign_a <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      q      <= '0;
      ovf    <= 1'b0;
      div0   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dvd    <= dvd_n;
      quo    <= quo_n;
      rem    <= rem_n;
      bmag   <= bmag_n;
      sign_q <= sign_q_n;
      sign_a <= sign_a_n;
      ready  <= ready_n;
      done   <= done_n;
      q      <= q_n;
      ovf    <= ovf_n;
      div0   <= div0_n;
    end
  end

endmodule

// File: tb/tb_signed_fixed_point_div.sv
// Self-checking bench for signed_fixed_point_div (D=F=16): directed spec
// vectors, handshake/reset scenarios and randomized operands against an
// arithmetic reference model.
module tb_signed_fixed_point_div;

  localparam int unsigned D = 16;
  localparam int unsigned F = 16;
  localparam int unsigned W = D + F;
`ifdef FIXED_DIV_ROUND_EN
  localparam int unsigned N = W + F + 1;
`else
  localparam int unsigned N = W + F;
`endif
  localparam logic [W-1:0] QMAXV = 32'h7FFF_FFFF;
  localparam logic [W-1:0] QMINV = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] q;
  logic         ovf;
  logic         div0;

  int checks = 0;
  int errors = 0;

  signed_fixed_point_div #(.D(D), .F(F)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .q     (q),
    .ovf   (ovf),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient = (|a| * 2^F) / |b| in plain integer arithmetic.
  function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                output logic [W-1:0] qo, output logic oo, output logic dz);
    longint unsigned am, bm, m, lim;
    logic [63:0] sv;
    bit sq;
    am  = ai[W-1] ? ((64'd1 << W) - 64'(ai)) : 64'(ai);
    bm  = bi[W-1] ? ((64'd1 << W) - 64'(bi)) : 64'(bi);
    sq  = ai[W-1] ^ bi[W-1];
    lim = 64'd1 << (W - 1);
    qo  = '0;
    oo  = 1'b0;
    dz  = 1'b0;
    if (bm == 0) begin
      dz = 1'b1;
      oo = 1'b1;
      qo = ai[W-1] ? QMINV : QMAXV;
    end else begin
`ifdef FIXED_DIV_ROUND_EN
      m = (((am << (F + 1)) / bm) + 1) >> 1;
`else
      m = (am << F) / bm;
`endif
      if (!sq && m > lim - 1) begin
        oo = 1'b1;
        qo = QMAXV;
      end else if (sq && m > lim) begin
        oo = 1'b1;
        qo = QMINV;
      end else begin
        sv = sq ? (64'd0 - m) : m;
        qo = sv[W-1:0];
      end
    end
  endfunction

  // One division: wait for ready, pulse start, count edges to done, check results.
  // poke != 0 drives a second start with other operands in the middle of CALC.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic [W-1:0] eq, input logic eo, input logic ed,
                        input string tag, input int poke);
    int k;
    int viol;
    bit got;
    k = 0;
    while (ready !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " ready_before"}, 64'(ready), 64'(1));
    a = ta;
    b = tbv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    viol = 0;
    for (k = 1; k <= int'(N) + 5; k++) begin
      @(posedge clk); #1;
      if (poke != 0 && k == 10) begin
        a = $urandom;
        b = $urandom;
        start = 1'b1;
      end
      if (poke != 0 && k == 11) start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (ready !== 1'b0) viol++;
    end
    chk({tag, " latency"}, 64'(k), 64'(N + 1));
    chk({tag, " ready_low_in_calc"}, 64'(viol), 64'(0));
    chk({tag, " q"}, 64'(q), 64'(eq));
    chk({tag, " ovf"}, 64'(ovf), 64'(eo));
    chk({tag, " div0"}, 64'(div0), 64'(ed));
    chk({tag, " ready_at_done"}, 64'(ready), 64'(got));
  endtask

  task automatic run_rand(input logic [W-1:0] ta, input logic [W-1:0] tbv, input string tag);
    logic [W-1:0] eq;
    logic eo, ed;
    model(ta, tbv, eq, eo, ed);
    run_op(ta, tbv, eq, eo, ed, tag, 0);
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    int sel;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'(1));
    chk("reset done", 64'(done), 64'(0));
    chk("reset q", 64'(q), 64'(0));
    chk("reset ovf", 64'(ovf), 64'(0));
    chk("reset div0", 64'(div0), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, "pos_3_div_2", 0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'(0));
`ifdef FIXED_DIV_ROUND_EN
    run_op(32'h0002_0000, 32'h0003_0000, 32'h0000_AAAB, 1'b0, 1'b0, "2_div_3", 0);
`else
    run_op(32'h0002_0000, 32'h0003_0000, 32'h0000_AAAA, 1'b0, 1'b0, "2_div_3", 0);
`endif
    run_op(32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, "m1_div_3", 0);
    run_op(32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, "pos_div0", 0);
    run_op(32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, "neg_div0", 0);
    run_op(32'h4000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1, 1'b0, "ovf_pos", 0);
    run_op(32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "min_div_m1", 0);
    run_op(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, "min_div_1", 0);
    run_op(32'h0000_0000, 32'hFFFD_0000, 32'h0000_0000, 1'b0, 1'b0, "zero_div_neg", 0);

    // Start during CALC is ignored; operands may change after acceptance.
    run_op(32'h0007_0000, 32'h0002_0000, 32'h0003_8000, 1'b0, 1'b0, "ignored_start", 1);
    // Back-to-back: second request issued in the done cycle of the first.
    run_op(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, "b2b_first", 0);
    run_op(32'hFFFA_0000, 32'h0004_0000, 32'hFFFE_8000, 1'b0, 1'b0, "b2b_second", 0);

    // Reset in the middle of CALC.
    @(posedge clk); #1;
    a = 32'h0003_0000;
    b = 32'h0002_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset ready", 64'(ready), 64'(1));
    chk("midreset q", 64'(q), 64'(0));
    chk("midreset ovf", 64'(ovf), 64'(0));
    chk("midreset div0", 64'(div0), 64'(0));
    chk("midreset done", 64'(done), 64'(0));
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    chk("midreset no_done", 64'(dones), 64'(0));
    run_op(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, "after_reset", 0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 32'h0003_FFFF));
        2: rb = 32'(0) - 32'($urandom_range(1, 32'h0003_FFFF));
        3: begin
          ra = 32'($signed(ra) >>> $urandom_range(8, 20));
          rb = $urandom;
        end
        default: rb = $urandom;
      endcase
      run_rand(ra, rb, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
